// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side controller for the team's synchronous FIFO.
// It issues FIFO reads, captures the registered read data one cycle later, and
// presents the words on a valid/ready stream through a 3-entry buffer. The
// read strobe depends only on registered state and the FIFO flag, never on
// m_ready, so the FIFO read path stays short while one word per clock is
// sustained.
// Optional build macro: FIFO_STREAM_READER_PKT_LAST_EN enables m_last framing
// every PKT_LEN popped words. Without it m_last is tied low.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int         DEPTH    = 3;
    localparam logic [1:0] LAST_IDX = 2'd2;
    localparam logic [2:0] DEPTH_V  = 3'd3;

    // A packet must hold at least one word.
    if (PKT_LEN < 1) begin : g_pkt_len_invalid
        $error("fifo_stream_reader: PKT_LEN must be at least 1");
    end

    // Buffer storage and bookkeeping
    logic [DATA_WIDTH-1:0] buf_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] buf_d [0:DEPTH-1];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q,  count_d;
    logic                  inflight_q, inflight_d;

    // Registered stream-side outputs
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
    logic                  busy_q,    busy_d;

    // Control strobes
    logic                  push_s;
    logic                  pop_s;
    logic                  rd_en_s;
    logic [2:0]            occupancy_s;

    // Advance a buffer pointer, wrapping 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] r;
        case (p)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            LAST_IDX: r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Words owed to downstream: buffered plus the one still in flight from the FIFO.
    assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_q};
    // A read is only issued when its word is guaranteed a free buffer slot.
    assign rd_en_s     = reset_n && drain_en && !fifo_empty && (occupancy_s < DEPTH_V);
    assign push_s      = inflight_q;
    assign pop_s       = m_valid_q && m_ready;

    assign fifo_rd_en  = rd_en_s;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign busy        = busy_q;

    // Buffer next state: capture landing FIFO data at the tail, retire the head on pop.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = rd_en_s;

        if (push_s) begin
            buf_d[wr_ptr_q] = fifo_data_out;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Stream outputs next state: pre-compute what the buffer head will be after the edge.
    always_comb begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
        busy_d    = 1'b0;
        if (count_d != 2'd0) begin
            m_valid_d = 1'b1;
        end else begin
            m_valid_d = 1'b0;
        end
        m_data_d = buf_d[rd_ptr_d];
        busy_d   = inflight_d || (count_d != 2'd0);
    end

    // Main state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            busy_q     <= busy_d;
        end
    end

`ifdef FIFO_STREAM_READER_PKT_LAST_EN
    localparam int                     PKT_CNT_W = $clog2(PKT_LEN) + 1;
    localparam logic [PKT_CNT_W-1:0]   PKT_LAST_V = PKT_CNT_W'(PKT_LEN - 1);

    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 m_last_q,  m_last_d;

    // Packet position: count popped words, wrapping after the packet's last word.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        m_last_d  = 1'b0;
        if (pop_s) begin
            if (m_last_q) begin
                pkt_cnt_d = '0;
            end else begin
                pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
            end
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if ((count_d != 2'd0) && (pkt_cnt_d == PKT_LAST_V)) begin
            m_last_d = 1'b1;
        end else begin
            m_last_d = 1'b0;
        end
    end

    // Packet counter and registered m_last with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_cnt_q <= '0;
            m_last_q  <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_last = m_last_q;
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a behavioural FIFO feeds the
// DUT, a scoreboard queue holds the words loaded into the FIFO, and a monitor
// checks delivery order, the read-issue rule, stall stability and m_last.
module tb_fifo_stream_reader;

    localparam int DW  = 8;
    localparam int PKT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          drain_en = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural FIFO: tail written by stimulus, head by the read process
    logic [DW-1:0] mem [0:1023];
    int            head = 0;
    int            tail = 0;
    logic [DW-1:0] exp_q [$];
    bit            mon_en = 1'b0;

    assign fifo_empty = (head == tail);

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk(clk), .reset_n(reset_n), .drain_en(drain_en), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO read port: registered data one cycle after rd_en
    always @(posedge clk) begin
        if (fifo_rd_en && (head != tail)) begin
            fifo_data_out <= mem[head];
            head          <= head + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        mem[tail] = v;
        tail      = tail + 1;
        exp_q.push_back(v);
    endtask

    task automatic flush_fifo();
        tail = head;
        exp_q.delete();
    endtask

    function automatic bit exp_last(input int n);
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
        return (n % PKT) == 0;
`else
        return (n < 0);
`endif
    endfunction

    // Monitor: reference model of outstanding words and packet position, scoreboard pops.
    int            outstanding = 0;
    int            popcnt = 0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n) begin
                chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
                outstanding = 0;
                popcnt      = 0;
                prev_hold   = 1'b0;
            end else begin
                bit exp_rd;
                bit pop;
                exp_rd = drain_en && !fifo_empty && (outstanding < 3);
                chk("rd_en_rule", 32'(fifo_rd_en), 32'(exp_rd));
                if (prev_hold) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'(m_data), 32'(prev_data));
                    chk("hold_last", 32'(m_last), 32'(prev_last));
                end
                pop = m_valid && m_ready;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        popcnt++;
                        chk("data_order", 32'(m_data), 32'(e));
                        chk("m_last_pos", 32'(m_last), 32'(exp_last(popcnt)));
                    end
                end else if (!m_valid) begin
                    chk("idle_last", 32'(m_last), 32'd0);
                end
                outstanding = outstanding + int'(fifo_rd_en) - int'(pop);
                prev_hold   = m_valid && !m_ready;
                prev_data   = m_data;
                prev_last   = m_last;
            end
        end
    end

    task automatic wait_drain(input int maxc);
        int c;
        c = 0;
        while (((exp_q.size() != 0) || busy) && (c < maxc)) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", 32'(c < maxc), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        flush_fifo();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic stream_last(input bit stall, output logic [9:0] pos);
        int n;
        pos = '0;
        n   = 0;
        do_reset();
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) load(DW'(8'h40 + i));
        for (int c = 0; (c < 300) && (n < 10); c++) begin
            m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_valid && m_ready) begin
                pos[n] = m_last;
                n++;
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        chk("last_words_seen", 32'(n), 32'd10);
        wait_drain(50);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            first_rd, first_pop, last_pop, pops, reads;
        logic [9:0]    lpos;
        logic [9:0]    lexp;

        // 1. reset with a non-empty FIFO and drain enabled
        drain_en = 1'b1;
        m_ready  = 1'b0;
        for (int i = 0; i < 4; i++) load(DW'(8'hA0 + i));
        @(posedge clk); #1;
        chk("reset_rd_en_1", 32'(fifo_rd_en), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_rd_en_2", 32'(fifo_rd_en), 32'd0);
        flush_fifo();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_m_last", 32'(m_last), 32'd0);

        // 2. streaming 0x01..0x20 at full rate
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 1; i <= 32; i++) load(DW'(i));
        first_rd = -1; first_pop = -1; last_pop = -1; pops = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fifo_rd_en && (first_rd < 0)) first_rd = c;
            if (m_valid && m_ready) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                pops++;
            end
        end
        chk("stream_pops", 32'(pops), 32'd32);
        chk("stream_fill_latency", 32'(first_pop - first_rd), 32'd2);
        chk("stream_back_to_back", 32'(last_pop - first_pop), 32'd31);
        chk("stream_end_valid", 32'(m_valid), 32'd0);
        chk("stream_end_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("stream_end_busy", 32'(busy), 32'd0);

        // 3. backpressure: only three reads, head word held
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(DW'(8'h10 + i));
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        chk("bp_reads", 32'(reads), 32'd3);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_head", 32'(m_data), 32'h10);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain(60);

        // 4. drain_en dropped while a read is in flight
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) load(DW'(8'h60 + i));
        reads = 0;
        for (int c = 0; (c < 10) && (reads == 0); c++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
        end
        chk("de_first_read", 32'(reads), 32'd1);
        @(posedge clk); #1;
        drain_en = 1'b0;
        #1;
        chk("de_stop_same_cycle", 32'(fifo_rd_en), 32'd0);
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
        end
        chk("de_no_reads", 32'(reads), 32'd0);
        chk("de_inflight_delivered", 32'(exp_q.size()), 32'(tail - head));
        chk("de_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        drain_en = 1'b1;
        wait_drain(60);

        // 5. reset while two words buffered and one in flight
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(DW'(8'hC0 + i));
        reads = 0;
        for (int c = 0; (c < 10) && (reads < 3); c++) begin
            @(negedge clk);
            if (fifo_rd_en) reads++;
        end
        chk("mr_reads", 32'(reads), 32'd3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        flush_fifo();
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("mr_valid", 32'(m_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_data", 32'(m_data), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mr_no_stale", 32'(m_valid), 32'd0);
        end

        // 6. randomized load, stall and drain_en traffic
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            m_ready  = ($urandom_range(0, 3) != 0);
            drain_en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) load(DW'($urandom));
        end
        @(posedge clk); #1;
        drain_en = 1'b1;
        m_ready  = 1'b1;
        wait_drain(300);

        // 7. packet framing: 10 words, without and with stalls
`ifdef FIFO_STREAM_READER_PKT_LAST_EN
        lexp = 10'h088;
`else
        lexp = 10'h000;
`endif
        stream_last(1'b0, lpos);
        chk("last_positions", 32'(lpos), 32'(lexp));
        stream_last(1'b1, lpos);
        chk("last_positions_stall", 32'(lpos), 32'(lexp));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
